axis_keep_unpacker: RTL

//  Wide-to-narrow AXI-Stream stage: takes one beat of T_DATA_RATIO lanes plus a per-lane

---
 rtl/axis_unpack_pkg.sv | 28 ++
 rtl/lane_prio_enc.sv | 20 ++
 rtl/axis_keep_unpacker.sv | 129 ++++++++++++
 3 files changed

// File: rtl/axis_unpack_pkg.sv
// Shared types and helpers for the wide-to-narrow AXI-Stream keep unpacker.
// DEF_* values are the default build configuration used by axis_keep_unpacker.
package axis_unpack_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_DATA_RATIO = 2;
    // Widest lane mask the generic mask helpers accept; callers zero-extend.
    localparam int unsigned MAX_LANES      = 32;

    typedef logic [$clog2(DEF_DATA_RATIO)-1:0] lane_idx_t;
    typedef logic [MAX_LANES-1:0]              wide_mask_t;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic lane_idx_t lowest_set(input logic [DEF_DATA_RATIO-1:0] mask);
        lane_idx_t idx;
        idx = '0;
        for (int i = int'(DEF_DATA_RATIO) - 1; i >= 0; i--) begin
            if (mask[i]) idx = lane_idx_t'(i);
        end
        return idx;
    endfunction

    // True when exactly one bit of the mask is set.
    function automatic bit is_onehot(input wide_mask_t mask);
        return (mask != '0) && ((mask & (mask - wide_mask_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/lane_prio_enc.sv
// Lowest-set-bit priority encoder over an N-lane mask.
// Lane 0 has highest priority; an empty mask encodes to 0.
module lane_prio_enc #(
    parameter  int unsigned N     = 2,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     mask_i,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top lane down so the lowest set lane wins.
    always_comb begin
        // NOTE: a default before the loop keeps every path assigned, so no latch is inferred.
        idx_o = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (mask_i[i]) idx_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/axis_keep_unpacker.sv
// Wide-to-narrow AXI-Stream unpacker: emits only the kept lanes of each wide
// beat as single-lane beats, lowest lane first, carrying last onto the final one.
// A beat with no kept lanes but last set becomes one terminator beat on lane 0.
// Optional build macro AXIS_UNPACK_KEEP_OUT_EN adds m_keep_o, low on terminator beats.
module axis_keep_unpacker
    import axis_unpack_pkg::*;
#(
    parameter int unsigned T_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned T_DATA_RATIO = DEF_DATA_RATIO
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [T_DATA_WIDTH*T_DATA_RATIO-1:0] s_data_i,
    input  logic [T_DATA_RATIO-1:0]              s_keep_i,
    input  logic                                 s_last_i,
    input  logic                                 s_valid_i,
    output logic                                 s_ready_o,
    output logic [T_DATA_WIDTH-1:0]              m_data_o,
    output logic                                 m_last_o,
    output logic                                 m_valid_o,
`ifdef AXIS_UNPACK_KEEP_OUT_EN
    output logic                                 m_keep_o,
`endif
    input  logic                                 m_ready_i
);

    localparam int unsigned IDX_W = $clog2(T_DATA_RATIO);

    // IDLE when busy_q is low, SERIALIZE when high.
    logic                                 busy_q,     busy_d;
    logic [T_DATA_RATIO-1:0]              rem_mask_q, rem_mask_d;
    logic [T_DATA_WIDTH*T_DATA_RATIO-1:0] data_q,     data_d;
    logic                                 last_q,     last_d;
`ifdef AXIS_UNPACK_KEEP_OUT_EN
    logic                                 null_q,     null_d;
`endif

    logic [IDX_W-1:0] idx;
    logic             final_lane;
    logic             narrow_hs;
    logic             accept;

    lane_prio_enc #(
        .N (T_DATA_RATIO)
    ) u_lane_prio_enc (
        .mask_i (rem_mask_q),
        .idx_o  (idx)
    );

    // Handshake qualifiers: a new wide beat may land on the cycle the last lane leaves.
    always_comb begin
        final_lane = is_onehot(wide_mask_t'(rem_mask_q));
        narrow_hs  = busy_q & m_ready_i;
        s_ready_o  = ~rst & (~busy_q | (narrow_hs & final_lane));
        accept     = s_valid_i & s_ready_o;
    end

    // Outputs come straight from the held beat so nothing on s_* reaches m_*.
    always_comb begin
        m_valid_o = busy_q;
        m_data_o  = data_q[idx*T_DATA_WIDTH +: T_DATA_WIDTH];
        m_last_o  = busy_q & final_lane & last_q;
`ifdef AXIS_UNPACK_KEEP_OUT_EN
        m_keep_o  = busy_q & ~null_q;
`endif
    end

    // Next-state: retire the emitted lane, then let an accepted beat take over.
    always_comb begin
        busy_d     = busy_q;
        rem_mask_d = rem_mask_q;
        data_d     = data_q;
        last_d     = last_q;
`ifdef AXIS_UNPACK_KEEP_OUT_EN
        null_d     = null_q;
`endif

        if (narrow_hs) begin
            rem_mask_d[idx] = 1'b0;
            if (final_lane) busy_d = 1'b0;
        end

        if (accept) begin
            data_d = s_data_i;
            last_d = s_last_i;
            if (s_keep_i != '0) begin
                busy_d     = 1'b1;
                rem_mask_d = s_keep_i;
`ifdef AXIS_UNPACK_KEEP_OUT_EN
                null_d     = 1'b0;
`endif
            end else if (s_last_i) begin
                // Empty last beat still has to mark packet end: emit lane 0 as a terminator.
                busy_d     = 1'b1;
                rem_mask_d = T_DATA_RATIO'(1);
`ifdef AXIS_UNPACK_KEEP_OUT_EN
                null_d     = 1'b1;
`endif
            end else begin
                // Empty non-last beat is swallowed without producing output.
                busy_d     = 1'b0;
                rem_mask_d = '0;
            end
        end
    end

    // State registers; reset discards any beat still being serialized.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= 1'b0;
            rem_mask_q <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
`ifdef AXIS_UNPACK_KEEP_OUT_EN
            null_q     <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            busy_q     <= busy_d;
            rem_mask_q <= rem_mask_d;
            data_q     <= data_d;
            last_q     <= last_d;
`ifdef AXIS_UNPACK_KEEP_OUT_EN
            null_q     <= null_d;
`endif
        end
    end

endmodule
